// File: rtl/equal_scheduler.sv
// Shares one bit-serial equality engine between two four-phase requesters.
// Compares one operand bit per cycle, LSB first, stopping at the first mismatch.
module equal_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             ack0,
  output logic             ack1,
  output logic             equal,
  output logic             notEqual,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             eq_q, eq_d, ne_q, ne_d;
  logic             busy_q, busy_d;

  logic greq, win, any_req, bit_diff, at_last;

  assign greq     = grant_q ? req1 : req0;
  assign any_req  = req0 | req1;
  // On a tie the side that was not served last wins; otherwise whoever asks.
  assign win      = (req0 && req1) ? ~last_q : req1;
  assign bit_diff = xs_q[idx_q] ^ ys_q[idx_q];
  assign at_last  = (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      idx_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      eq_q    <= 1'b0;
      ne_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      eq_q    <= eq_d;
      ne_q    <= ne_d;
      busy_q  <= busy_d;
    end
  end

  // Operand latches carry no control meaning, so they are left out of reset.
  always_ff @(posedge clk) begin
    xs_q <= xs_d;
    ys_q <= ys_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = COMPARE;
      COMPARE: begin
        if (!greq)                    state_d = IDLE;
        else if (bit_diff || at_last) state_d = DONE;
      end
      DONE:    if (!greq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    idx_d   = idx_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    eq_d    = eq_q;
    ne_d    = ne_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
          xs_d    = win ? x1 : x0;
          ys_d    = win ? y1 : y0;
          idx_d   = '0;
        end
      end
      COMPARE: begin
        if (!greq) begin
          last_d = grant_q;
        end else if (bit_diff || at_last) begin
          ne_d   = bit_diff;
          eq_d   = ~bit_diff;
          ack0_d = ~grant_q;
          ack1_d = grant_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (!greq) begin
          ack0_d = 1'b0;
          ack1_d = 1'b0;
          eq_d   = 1'b0;
          ne_d   = 1'b0;
          last_d = grant_q;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign equal    = eq_q;
  assign notEqual = ne_q;
  assign busy     = busy_q;

endmodule

// File: doc/equal_scheduler.md
# equal_scheduler

Clocked controller that shares one bit-serial equality engine between two requesters. It applies the single-bit `equal`/`notEqual` function to one operand bit per cycle, LSB first, and terminates early on the first mismatch. Requesters use a four-phase req/ack handshake, and simultaneous requests are served round-robin. It sits in FlowControl beside the equality cells, as the sequencer for multi-bit compares in clocked islands.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits, ≥1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0`, input, 1: requester 0 request; held high until `ack0`.
- `x0`, `y0`, input, WIDTH each: requester 0 operands; sampled at grant only.
- `req1`, input, 1: requester 1 request.
- `x1`, `y1`, input, WIDTH each: requester 1 operands.
- `ack0`, `ack1`, output, 1 each: result-valid acknowledge to the granted requester.
- `equal`, output, 1: result, all bits matched; valid while `ack0` or `ack1` is high.
- `notEqual`, output, 1: result, some bit differed; valid while `ack0` or `ack1` is high.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, COMPARE and DONE. Internal state:
  - `grant`: 1 bit.
  - `last`: round-robin pointer, the requester served last.
  - `idx`: bit index, ceil(log2(WIDTH)) bits, minimum 1.
  - `xs`, `ys`: operand latches, WIDTH bits each.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request high: grant that requester.
- IDLE, both requests high: grant the requester that is not `last`.
- IDLE, on grant:
  - Latch the winner's x/y into `xs`/`ys`.
  - Set `idx`=0 and go to COMPARE.
- COMPARE, each cycle, evaluated in this priority order:
  1. Granted req low: abort. Go to IDLE with no ack and no result, and set `last`=`grant`.
  2. `xs[idx]`≠`ys[idx]`: set `notEqual`=1 and the granted ack=1, then go to DONE.
  3. `idx`==WIDTH-1 with the bits equal: set `equal`=1 and the granted ack=1, then go to DONE.
  4. Otherwise: `idx`++.
- DONE:
  - Hold the ack and the result.
  - When the granted req is sampled low: clear the ack, `equal` and `notEqual`, set `last`=`grant`, and go to IDLE.
- The non-granted requester waits with its req held. It is never acked out of turn.
- Operand changes after grant are ignored.
- `equal` and `notEqual` are never both high.
- Both are low whenever no ack is high.

## Timing
- Reset values:
  - State IDLE.
  - `ack0`=`ack1`=0, `equal`=`notEqual`=0, `busy`=0.
  - `last`=1, so requester 0 wins the first tie.
  - `idx`=0.
- Reset asserted in any state, including mid-COMPARE or DONE: all outputs are 0 after that edge. The in-flight compare is discarded and the pointer returns to its reset value.
- Grant edge G is the edge at which IDLE samples a request.
  - First mismatch at bit k: ack and `notEqual` are high after edge G+k+1.
  - Full match: ack and `equal` are high after edge G+WIDTH.
- Release: the granted req sampled low at edge R drops the ack and result after R.
  - IDLE can grant again at edge R+1.
  - Minimum request-to-request turnaround is 1 idle cycle.
- All outputs are registered; no combinational path exists from inputs to outputs.
- WIDTH=1: the COMPARE phase lasts exactly one cycle for both outcomes.

## Test plan
1. **Reset:** drive random inputs with `rst`=1 for 3 cycles. All outputs must be 0, and `busy`=0.
2. **Full match:** WIDTH=8, `req0`=1, `x0`=`y0`=0xA5.
   - `ack0`=1 with `equal`=1 and `notEqual`=0 exactly 8 edges after grant.
   - Dropping `req0` clears `ack0` and `equal` on the next edge.
3. **Early mismatch:** `req1`=1, `x1`=0x0F, `y1`=0x0E. Expect `ack1`=1 and `notEqual`=1 one edge after grant.
4. **Late mismatch:** `x0`=0x80, `y0`=0x00. Expect `notEqual` and `ack0` 8 edges after grant, and `equal` never asserted.
5. **Round-robin:** hold `req0` and `req1` both high from reset, each re-raised after its own release.
   - Service order must be 0, 1, 0, 1.
   - The waiting side's ack must stay 0 while the other is served.
6. **Abort and reset:**
   - Drop `req0` at bit 3 of an equal 0xFF/0xFF compare. Expect no ack and a return to IDLE; a pending `req1` is then granted.
   - Assert `rst` in DONE. Outputs must be 0 after that edge, and the next tie goes to requester 0.
